// File: rtl/keypad_digit_entry.sv
// Debounced 16-bit one-hot keypad to BCD entry buffer; ENTER hands the number out on a valid/ready port.
// Action lands DEBOUNCE_CYC+1 edges after the code reaches the sample reg; a stalled output blocks ENTER. Optional KEY_REPEAT_EN.
module keypad_digit_entry #(
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TRIES_W      = 8,
  parameter int MAX_TRIES    = 255,
  parameter int REPEAT_DLY   = 1000,
  parameter int REPEAT_PER   = 200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   onehot,
  output logic [4*DIGITS-1:0]           entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*DIGITS-1:0]           out_value,
  output logic [TRIES_W-1:0]            tries_out,
  output logic                          locked,
  output logic                          err_multi
);

  localparam int ENTRY_W = 4 * DIGITS;
  localparam int CNTW    = $clog2(DIGITS + 1);
  localparam int CW      = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {K_NONE, K_DIGIT, K_ENTER, K_CLEAR} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [3:0] digit;
  } key_t;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;

  function automatic key_t decode(input logic [15:0] c);
    key_t k;
    k.kind  = K_NONE;
    k.digit = 4'd0;
    case (c)
      16'h0008: begin k.kind = K_DIGIT; k.digit = 4'd0; end
      16'h0080: begin k.kind = K_DIGIT; k.digit = 4'd1; end
      16'h0040: begin k.kind = K_DIGIT; k.digit = 4'd2; end
      16'h0020: begin k.kind = K_DIGIT; k.digit = 4'd3; end
      16'h0800: begin k.kind = K_DIGIT; k.digit = 4'd4; end
      16'h0400: begin k.kind = K_DIGIT; k.digit = 4'd5; end
      16'h0200: begin k.kind = K_DIGIT; k.digit = 4'd6; end
      16'h8000: begin k.kind = K_DIGIT; k.digit = 4'd7; end
      16'h4000: begin k.kind = K_DIGIT; k.digit = 4'd8; end
      16'h2000: begin k.kind = K_DIGIT; k.digit = 4'd9; end
      16'h0001: k.kind = K_ENTER;
      16'h0010: k.kind = K_CLEAR;
      default:  k.kind = K_NONE;
    endcase
    return k;
  endfunction

  logic [15:0]   samp;
  state_t        state;
  logic [CW-1:0] cnt;
  key_t          held;
  key_t          cur;
  logic          same;
  logic          multi;
  logic          db_fire;
  logic          fire;
  logic          enter_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp <= '0;
    else        samp <= onehot;
  end

  always_comb begin
    cur     = decode(samp);
    same    = (cur.kind != K_NONE) && (cur == held);
    multi   = ($countones(samp) > 1);
    db_fire = (state == S_DEBOUNCE) && same && (cnt == CW'(DEBOUNCE_CYC));
  end

  // In HELD, cnt is reused as the release counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      held  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cur.kind != K_NONE) begin
            state <= S_DEBOUNCE;
            cnt   <= CW'(1);
            held  <= cur;
          end
        end
        S_DEBOUNCE: begin
          if (cur.kind == K_NONE) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (!same) begin
            held <= cur;
            cnt  <= CW'(1);
          end else if (cnt == CW'(DEBOUNCE_CYC)) begin
            state <= S_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HELD: begin
          if (same) begin
            cnt <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_lim;
  logic          rpt_first;
  logic          rpt_fire;

  always_comb begin
    rpt_lim  = rpt_first ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1);
    rpt_fire = (state == S_HELD) && same && (held.kind == K_DIGIT) && (rpt_cnt == rpt_lim);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state != S_HELD || !same) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end

  assign fire = db_fire | rpt_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DLY[0], REPEAT_PER[0]};
  assign fire = db_fire;
`endif

  assign locked   = (tries_out == TRIES_W'(MAX_TRIES));
  assign enter_ok = !locked && (digit_cnt != '0) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_bcd <= '0;
      digit_cnt <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      tries_out <= '0;
      err_multi <= 1'b0;
    end else begin
      err_multi <= multi;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (fire) begin
        case (held.kind)
          K_DIGIT: begin
            if (!locked && digit_cnt != CNTW'(DIGITS)) begin
              entry_bcd <= (entry_bcd << 4) | ENTRY_W'(held.digit);
              digit_cnt <= digit_cnt + CNTW'(1);
            end
          end
          K_CLEAR: begin
            entry_bcd <= '0;
            digit_cnt <= '0;
          end
          K_ENTER: begin
            // An accepted ENTER in the transfer cycle keeps out_valid high.
            if (enter_ok) begin
              out_value <= entry_bcd;
              out_valid <= 1'b1;
              entry_bcd <= '0;
              digit_cnt <= '0;
              if (tries_out != TRIES_W'(MAX_TRIES)) tries_out <= tries_out + TRIES_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with a per-cycle reference model of presses, entry and handshake.
module tb_keypad_digit_entry;

  localparam int DIG = 4;
  localparam int DB  = 4;
  localparam int MT  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] onehot = '0;
  logic        out_ready = 1'b0;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_cnt;
  logic        out_valid;
  logic [15:0] out_value;
  logic [7:0]  tries_out;
  logic        locked;
  logic        err_multi;

  int errors = 0;
  int checks = 0;

  keypad_digit_entry #(
    .DIGITS(DIG), .DEBOUNCE_CYC(DB), .TRIES_W(8), .MAX_TRIES(MT),
    .REPEAT_DLY(1000), .REPEAT_PER(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .onehot(onehot),
    .entry_bcd(entry_bcd), .digit_cnt(digit_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .tries_out(tries_out), .locked(locked), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key acts once it has been seen for DB+1 consecutive
  // samples while armed; it re-arms after DB consecutive no-key samples.
  function automatic int key_of(input logic [15:0] c);
    case (c)
      16'h0008: return 0;  16'h0080: return 1;  16'h0040: return 2;
      16'h0020: return 3;  16'h0800: return 4;  16'h0400: return 5;
      16'h0200: return 6;  16'h8000: return 7;  16'h4000: return 8;
      16'h2000: return 9;  16'h0001: return 10; 16'h0010: return 11;
      default:  return -1;
    endcase
  endfunction

  logic [15:0] m_samp, m_last, m_entry, m_val;
  int          run, quiet, m_tries;
  bit          armed, m_vld, m_err;
  int          q[$];

  task automatic model_step();
    int k;
    bit act, lk, vld_old;
    if (!rst_n) begin
      m_samp = '0; m_last = '0; run = 0; quiet = 0; armed = 1'b1;
      q.delete(); m_vld = 1'b0; m_val = '0; m_tries = 0; m_err = 1'b0; m_entry = '0;
      return;
    end
    k = key_of(m_samp);
    if (k < 0) run = 0;
    else if (m_samp == m_last) run++;
    else run = 1;
    m_last = m_samp;
    act = 1'b0;
    if (armed) begin
      if (k >= 0 && run == DB + 1) begin act = 1'b1; armed = 1'b0; quiet = 0; end
    end else begin
      if (k < 0) quiet++; else quiet = 0;
      if (quiet == DB) armed = 1'b1;
    end
    lk = (m_tries == MT);
    m_err = ($countones(m_samp) > 1);
    vld_old = m_vld;
    if (vld_old && out_ready) m_vld = 1'b0;
    if (act) begin
      if (k <= 9) begin
        if (!lk && q.size() < DIG) q.push_back(k);
      end else if (k == 11) begin
        q.delete();
      end else if (!lk && q.size() > 0 && (!vld_old || out_ready)) begin
        m_val = m_entry;
        m_vld = 1'b1;
        q.delete();
        if (m_tries < MT) m_tries++;
      end
    end
    m_entry = '0;
    foreach (q[i]) m_entry = m_entry * 16 + 16'(q[i]);
    m_samp = onehot;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("entry_bcd", 32'(entry_bcd), 32'(m_entry));
    chk("digit_cnt", 32'(digit_cnt), q.size());
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) chk("out_value", 32'(out_value), 32'(m_val));
    chk("tries_out", 32'(tries_out), m_tries);
    chk("locked", 32'(locked), 32'(m_tries == MT));
    chk("err_multi", 32'(err_multi), 32'(m_err));
  end

  task automatic drive(input logic [15:0] code, input int cyc);
    @(negedge clk); #1;
    onehot = code;
    repeat (cyc) @(negedge clk);
    #1 onehot = '0;
  endtask

  task automatic press(input logic [15:0] code);
    drive(code, 10);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset entry", 32'(entry_bcd), 0);
    chk("reset tries", 32'(tries_out), 0);
    chk("reset valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single press of '1': visible after edge DB+1 and not before.
    @(negedge clk); #1 onehot = 16'h0080;
    repeat (5) @(posedge clk); #1;
    chk("press1 before edge5", 32'(entry_bcd), 0);
    @(posedge clk); #1;
    chk("press1 edge5 entry", 32'(entry_bcd), 32'h0001);
    chk("press1 edge5 cnt", 32'(digit_cnt), 1);
    repeat (4) @(negedge clk); #1 onehot = '0;
    repeat (10) @(negedge clk);
    chk("press1 single action", 32'(entry_bcd), 32'h0001);

    // Bouncing '2' then stable.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 onehot = 16'h0040;
      repeat (2) @(negedge clk); #1 onehot = '0;
      repeat (1) @(negedge clk);
    end
    press(16'h0040);
    chk("bounce entry", 32'(entry_bcd), 32'h0012);
    chk("bounce cnt", 32'(digit_cnt), 2);

    press(16'h0020); press(16'h0800); press(16'h0400);
    chk("full entry", 32'(entry_bcd), 32'h1234);
    chk("full cnt", 32'(digit_cnt), 4);
    press(16'h0010);
    chk("clear entry", 32'(entry_bcd), 0);
    chk("clear cnt", 32'(digit_cnt), 0);

    // Stalled output port.
    press(16'h0080); press(16'h0040); press(16'h0001);
    chk("enter valid", 32'(out_valid), 1);
    chk("enter value", 32'(out_value), 32'h0012);
    chk("enter tries", 32'(tries_out), 1);
    press(16'h0020); press(16'h0800); press(16'h0001);
    chk("stalled value", 32'(out_value), 32'h0012);
    chk("stalled tries", 32'(tries_out), 1);
    chk("stalled entry kept", 32'(entry_bcd), 32'h0034);
    @(negedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handshake drop", 32'(out_valid), 0);

    // Saturate tries and lock.
    press(16'h0400); press(16'h0001);
    chk("tries2 value", 32'(out_value), 32'h0345);
    press(16'h0200); press(16'h0001);
    press(16'h8000); press(16'h0001);
    chk("locked tries", 32'(tries_out), 3);
    chk("locked flag", 32'(locked), 1);
    press(16'h4000);
    chk("locked digit ignored", 32'(digit_cnt), 0);
    press(16'h0010);
    chk("locked clear", 32'(entry_bcd), 0);

    // Multi-hot code.
    @(negedge clk); #1 onehot = 16'h0088;
    repeat (2) @(posedge clk); #1;
    chk("multi pulse", 32'(err_multi), 1);
    repeat (8) @(negedge clk); #1 onehot = '0;
    repeat (10) @(negedge clk);
    chk("multi no action", 32'(digit_cnt), 0);

    // Asynchronous reset in the middle of debouncing '9'.
    @(negedge clk); #1 onehot = 16'h2000;
    repeat (2) @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst tries", 32'(tries_out), 0);
    chk("arst locked", 32'(locked), 0);
    chk("arst entry", 32'(entry_bcd), 0);
    repeat (2) @(negedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk); #1 onehot = '0;
    repeat (10) @(negedge clk);
    chk("rekey entry", 32'(entry_bcd), 32'h0009);
    chk("rekey cnt", 32'(digit_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
